// File: rtl/pipeline_types.sv
// Shared types for the frame sequencer: FSM state encoding and pixel/output records.
package pipeline_types;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        DRAIN   = 2'd2
    } frame_seq_state_e;

    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } pixel_t;

    localparam int unsigned OUTPUT_INDEX_BITS = 6;

    typedef struct packed {
        logic                         valid;
        pixel_t                       data;
        logic [OUTPUT_INDEX_BITS-1:0] index;
    } frame_seq_output_t;

endpackage

// File: rtl/idle_timer.sv
// Counts quiet-line cycles and flags the single cycle in which the count reaches RESET_CYCLES.
module idle_timer #(
    parameter int RESET_CYCLES = 2500
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_timeout
);

    localparam int CW = $clog2(RESET_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT = CW'(RESET_CYCLES);
    localparam logic [CW-1:0] LAST  = CW'(RESET_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (count != LIMIT) begin
            count <= count + 1'b1;
        end
    end

    // Fires only on the step into LIMIT; a saturated count never re-fires.
    assign o_timeout = i_enable && !i_clear && (count == LAST);

endmodule

// File: rtl/frame_sequencer.sv
// Assembles a decoded serial bit stream into pixels, hands them out over valid/ready
// and delimits frames with a line-idle timeout.
module frame_sequencer
    import pipeline_types::*;
#(
    parameter  int PIXEL_BITS   = 24,
    parameter  int MAX_PIXELS   = 64,
    parameter  int RESET_CYCLES = 2500,
    localparam int INDEX_BITS   = (MAX_PIXELS > 1) ? $clog2(MAX_PIXELS) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_line,
    input  logic                  i_bit_valid,
    input  logic                  i_bit,
    output logic                  o_pixel_valid,
    input  logic                  i_pixel_ready,
    output logic [PIXEL_BITS-1:0] o_pixel_data,
    output logic [INDEX_BITS-1:0] o_pixel_index,
    output logic                  o_frame_done,
    output logic                  o_frame_error,
    output logic                  o_overflow,
    output logic                  o_busy
);

    // Output handshake: a pixel moves on any cycle where o_pixel_valid && i_pixel_ready;
    // while valid is high and ready low, data and index are frozen.

    localparam int BIT_W = $clog2(PIXEL_BITS + 1);
    localparam int CNT_W = $clog2(MAX_PIXELS + 1);

    frame_seq_state_e state, state_next;

    logic [PIXEL_BITS-2:0] shift_q;
    logic [BIT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      pix_cnt;
    logic [PIXEL_BITS-1:0] assembled;
    logic accept_bit, pixel_done, transfer, index_full, can_load;
    logic timeout, abort, drain_exit;

    idle_timer #(
        .RESET_CYCLES(RESET_CYCLES)
    ) u_idle_timer (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (i_line | i_bit_valid),
        .i_enable  (state == RECEIVE),
        .o_timeout (timeout)
    );

    assign accept_bit = i_bit_valid && (state != DRAIN);
    assign pixel_done = accept_bit && (bit_cnt == BIT_W'(PIXEL_BITS - 1));
    assign assembled  = {shift_q, i_bit};
    assign transfer   = o_pixel_valid && i_pixel_ready;
    // pix_cnt saturates at MAX_PIXELS, so reaching it means every later pixel is dropped.
    assign index_full = (pix_cnt == CNT_W'(MAX_PIXELS));
    assign can_load   = !index_full && (!o_pixel_valid || transfer);
    assign abort      = (state == RECEIVE) && timeout;
    assign drain_exit = (state == DRAIN) && !o_pixel_valid;
    assign o_busy     = (state != IDLE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_bit_valid) state_next = RECEIVE;
            RECEIVE: if (abort) state_next = DRAIN;
            DRAIN:   if (!o_pixel_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            shift_q       <= '0;
            bit_cnt       <= '0;
            pix_cnt       <= '0;
            o_pixel_valid <= 1'b0;
            o_pixel_data  <= '0;
            o_pixel_index <= '0;
            o_frame_done  <= 1'b0;
            o_frame_error <= 1'b0;
            o_overflow    <= 1'b0;
        end else begin
            o_frame_done  <= drain_exit;
            o_frame_error <= abort && (bit_cnt != '0);

            if (abort || drain_exit) begin
                shift_q <= '0;
                bit_cnt <= '0;
            end else if (accept_bit) begin
                shift_q <= assembled[PIXEL_BITS-2:0];
                bit_cnt <= pixel_done ? '0 : bit_cnt + 1'b1;
            end

            // Index advances for every completed pixel, whether it is delivered or dropped.
            if (drain_exit) begin
                pix_cnt <= '0;
            end else if (pixel_done && !index_full) begin
                pix_cnt <= pix_cnt + 1'b1;
            end

            if (pixel_done && can_load) begin
                o_pixel_valid <= 1'b1;
                o_pixel_data  <= assembled;
                o_pixel_index <= pix_cnt[INDEX_BITS-1:0];
            end else if (transfer) begin
                o_pixel_valid <= 1'b0;
            end

            if (pixel_done && !can_load) begin
                o_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/frame_sequencer.md
FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 Parameter PIXEL_BITS, default 24, bits per pixel (GRB order, MSB first).
REQ-002 Parameter MAX_PIXELS, default 64, pixels accepted per frame.
REQ-003 Parameter RESET_CYCLES, default 2500, consecutive low-line cycles that end a frame (50 us at 50 MHz).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Ports SHALL be:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_line  in  1  synchronised serial line level.
- i_bit_valid  in  1  one-cycle pulse: a decoded bit is present.
- i_bit  in  1  decoded bit value, qualified by i_bit_valid.
- o_pixel_valid  out  1  pixel output valid.
- i_pixel_ready  in  1  downstream accepts pixel.
- o_pixel_data  out  PIXEL_BITS  assembled pixel.
- o_pixel_index  out  clog2(MAX_PIXELS)  pixel position in frame.
- o_frame_done  out  1  one-cycle pulse at frame end.
- o_frame_error  out  1  one-cycle pulse when a partial pixel is discarded.
- o_overflow  out  1  sticky drop flag; clears only on reset.
- o_busy  out  1  high in any state other than IDLE.

Function
REQ-006 FSM states SHALL be IDLE, RECEIVE and DRAIN.
REQ-007 IDLE: on i_bit_valid, shift in i_bit, set bit count to 1, and go to RECEIVE.
REQ-008 RECEIVE: each i_bit_valid SHALL shift i_bit in MSB-first and increment the bit count.
REQ-009 On the PIXEL_BITS-th bit, the bit count SHALL clear, the pixel SHALL load into the output register, and o_pixel_valid SHALL rise the next cycle (latency 1).
REQ-010 o_pixel_data and o_pixel_index SHALL hold stable while o_pixel_valid && !i_pixel_ready; a transfer occurs on valid && ready.
REQ-011 If a pixel completes while the output register is still occupied and not transferring that cycle, the new pixel SHALL be dropped and o_overflow set.
  - Completion in the same cycle as a transfer SHALL load without drop.
REQ-012 Pixel index SHALL increment per completed pixel, loaded or dropped.
REQ-013 Pixels with index >= MAX_PIXELS SHALL be dropped and set o_overflow; the index saturates and never wraps.
REQ-014 Idle timer:
  - counts cycles with i_line==0 and i_bit_valid==0;
  - clears on i_line==1 or i_bit_valid;
  - saturates at RESET_CYCLES;
  - issues a single timeout when it reaches RESET_CYCLES in RECEIVE.
REQ-015 i_bit_valid in the timeout cycle SHALL take priority: the bit is shifted and the timer cleared.
REQ-016 On timeout with bit count != 0, the partial pixel SHALL be discarded, o_frame_error pulsed, and the FSM SHALL go to DRAIN.
REQ-017 DRAIN: i_bit_valid SHALL be ignored.
  - Once the output register is empty, o_frame_done SHALL pulse for one cycle.
  - Index and bit count SHALL clear, and the FSM SHALL return to IDLE.
REQ-018 o_frame_done and o_frame_error SHALL never stay high for two consecutive cycles.

Reset
REQ-019 On reset (any time, including mid-frame or mid-handshake), all of the following SHALL reset:
  - FSM to IDLE;
  - shift register, bit count, index and timer to 0;
  - o_pixel_valid, o_frame_done, o_frame_error, o_overflow and o_busy to 0;
  - o_pixel_data and o_pixel_index to 0.
REQ-020 After reset deassertion, the first i_bit_valid SHALL start a new frame; no state survives from before reset.

Structure
REQ-021 pipeline_types SHALL add:
  - frame_seq_state_e (IDLE/RECEIVE/DRAIN);
  - pixel_t (packed g, r, b, 8 bits each);
  - frame_seq_output_t (valid, data, index).
REQ-022 The idle timer SHALL be a sub-module named idle_timer (parameter RESET_CYCLES; ports i_clk, i_reset_n, i_clear, i_enable, o_timeout).
REQ-023 Sequencing, assembly and output register SHALL live in frame_sequencer; expected size 150-300 lines.

Verification
REQ-024 Bench SHALL cover the following scenarios (tests use PIXEL_BITS=24, RESET_CYCLES=16, MAX_PIXELS=4 unless stated):
- 48 bits 0xFF0000,0x00FF00, ready=1, then 20 low cycles -> two pixels: index 0 then 1, data as sent; one o_frame_done; no error or overflow.
- 24 bits 0x123456 with ready=0 for 10 cycles -> valid held, data and index stable until ready, single transfer.
- ready=0; two full pixels -> first held, second dropped, o_overflow=1 sticky.
- 6 pixels, ready=1 -> indices 0..3 delivered; pixels 5 and 6 dropped; o_overflow=1.
- 30 bits then timeout -> one pixel delivered, o_frame_error pulse, then o_frame_done, o_busy=0.
- Reset asserted at bit 12 of pixel 2 -> all outputs 0 immediately; next frame starts at index 0.
